// File: rtl/seq_pkg.sv
// Shared types for the 10110 sequence generator and detector.
// Holds the default pattern and the one-hot transmitter states.
package seq_pkg;

  localparam int unsigned SEQ_WIDTH = 5;
  localparam logic [SEQ_WIDTH-1:0] SEQ_PATTERN = 5'b10110;

  localparam int unsigned I_IDLE = 0;
  localparam int unsigned I_SEND = 1;
  localparam int unsigned I_GAP  = 2;
  localparam int unsigned I_DONE = 3;

  typedef enum logic [3:0] {
    S_IDLE = 4'b0001,
    S_SEND = 4'b0010,
    S_GAP  = 4'b0100,
    S_DONE = 4'b1000
  } tx_state_e;

endpackage

// File: rtl/seq_piso.sv
// Loadable parallel-in serial-out shift register, MSB first.
// Load has priority over shift; neither means hold.
module seq_piso #(
  parameter int unsigned WIDTH = 5
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             msb_o
);

  logic [WIDTH-1:0] sr;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sr <= '0;
    end else if (load_i) begin
      sr <= data_i;
    end else if (shift_i) begin
      sr <= sr << 1;
    end
  end

  assign msb_o = sr[WIDTH-1];

endmodule

// File: rtl/seq_gen_tx.sv
// Burst transmitter: sends PATTERN rep_i times, MSB first,
// with GAP_LEN zero bits between repetitions and a done pulse.
module seq_gen_tx
  import seq_pkg::*;
#(
  parameter int unsigned          WIDTH   = SEQ_WIDTH,
  parameter logic [WIDTH-1:0]     PATTERN = SEQ_PATTERN,
  parameter int unsigned          GAP_LEN = 2,
  parameter int unsigned          CNT_W   = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [CNT_W-1:0] rep_i,
  input  logic             stall_i,
  output logic             d_o,
  output logic             valid_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int GW = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
  localparam bit NO_GAP = (GAP_LEN == 0);

  tx_state_e        state;
  logic [BW-1:0]    bit_cnt;
  logic [GW-1:0]    gap_cnt;
  logic [CNT_W-1:0] rep_cnt;

  logic accept;
  logic last_bit;
  logic last_gap;
  logic last_rep;
  logic load;
  logic shift;
  logic msb;

  assign accept   = state[I_IDLE] & start_i & (|rep_i);
  assign last_bit = (bit_cnt == BW'(WIDTH - 1));
  assign last_gap = (gap_cnt == GW'(GAP_LEN - 1));
  assign last_rep = (rep_cnt == CNT_W'(1));

  // Reload on accept, on back-to-back repetitions, and at gap end.
  assign load = accept
    | (state[I_SEND] & ~stall_i & last_bit
       & ~last_rep & NO_GAP)
    | (state[I_GAP] & ~stall_i & last_gap);
  assign shift = state[I_SEND] & ~stall_i;

  seq_piso #(
    .WIDTH (WIDTH)
  ) u_piso (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .load_i  (load),
    .shift_i (shift),
    .data_i  (PATTERN),
    .msb_o   (msb)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= S_IDLE;
      bit_cnt <= '0;
      gap_cnt <= '0;
      rep_cnt <= '0;
    end else begin
      unique case (1'b1)
        state[I_IDLE]: begin
          if (accept) begin
            rep_cnt <= rep_i;
            bit_cnt <= '0;
            state   <= S_SEND;
          end
        end
        state[I_SEND]: begin
          if (!stall_i) begin
            if (last_bit) begin
              rep_cnt <= rep_cnt - CNT_W'(1);
              bit_cnt <= '0;
              gap_cnt <= '0;
              if (last_rep)
                state <= S_DONE;
              else if (NO_GAP)
                state <= S_SEND;
              else
                state <= S_GAP;
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
            end
          end
        end
        state[I_GAP]: begin
          if (!stall_i) begin
            if (last_gap) begin
              gap_cnt <= '0;
              bit_cnt <= '0;
              state   <= S_SEND;
            end else begin
              gap_cnt <= gap_cnt + GW'(1);
            end
          end
        end
        state[I_DONE]: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign d_o     = state[I_SEND] & msb;
  assign valid_o = (state[I_SEND] | state[I_GAP]) & ~stall_i;
  assign busy_o  = ~state[I_IDLE];
  assign done_o  = state[I_DONE];

endmodule

// File: tb/tb_seq_gen_tx.sv
// Bench for seq_gen_tx: two instances (GAP_LEN 2 and 0) against a
// queue-based stream model, plus literal burst expectations.
module tb_seq_gen_tx;

  localparam logic [4:0] PAT = 5'b10110;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stall = 1'b0;
  logic [3:0] rep = '0;
  logic [1:0] d, v, b, dn;

  seq_gen_tx #(.GAP_LEN(2)) u0 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .rep_i(rep),
    .stall_i(stall), .d_o(d[0]), .valid_o(v[0]), .busy_o(b[0]),
    .done_o(dn[0])
  );

  seq_gen_tx #(.GAP_LEN(0)) u1 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .rep_i(rep),
    .stall_i(stall), .d_o(d[1]), .valid_o(v[1]), .busy_o(b[1]),
    .done_o(dn[1])
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", nm, got, exp, $time);
    end
  endtask

  // Model: per instance, the remaining stream items of the burst.
  // 0/1 = bit to send (gap zeros included), 2 = done cycle.
  int         mq [2][$];
  int         mreps [2];
  int         det [2];
  int         det_last [2];
  logic [4:0] hist [2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) mq[k].delete();
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (mq[k].size() == 0) begin
          if (start && rep != 0) begin
            mreps[k] = int'(rep);
            for (int r = 0; r < int'(rep); r++) begin
              for (int i = 4; i >= 0; i--) mq[k].push_back(int'(PAT[i]));
              if (r < int'(rep) - 1)
                for (int g = 0; g < ((k == 0) ? 2 : 0); g++)
                  mq[k].push_back(0);
            end
            mq[k].push_back(2);
          end
        end else if (mq[k][0] == 2 || !stall) begin
          void'(mq[k].pop_front());
        end
      end
    end
  end

  logic be;
  int   h;

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      be = (mq[k].size() != 0);
      h  = be ? mq[k][0] : 0;
      chk($sformatf("busy%0d", k), int'(b[k]), int'(be));
      chk($sformatf("done%0d", k), int'(dn[k]), int'(be && h == 2));
      chk($sformatf("valid%0d", k), int'(v[k]),
          int'(be && h != 2 && !stall));
      chk($sformatf("d%0d", k), int'(d[k]), int'(be && h == 1));
      if (v[k]) begin
        hist[k] = {hist[k][3:0], d[k]};
        if (hist[k] == PAT) det[k]++;
      end
      if (dn[k]) begin
        chk($sformatf("detections%0d", k), det[k], mreps[k]);
        det_last[k] = det[k];
      end
      if (!be) begin
        det[k]  = 0;
        hist[k] = '0;
      end
    end
  end

  int rd [2][40];
  int rv [2][40];
  int rb [2][40];
  int rdn [2][40];

  task automatic burst(input int r, input int slo, input int shi,
                       input bit spam, input int n);
    for (int c = 0; c < n; c++) begin
      start = (c == 0) || (spam && b[0] && ($urandom_range(1) == 1));
      rep   = (c == 0) ? r[3:0] : 4'($urandom_range(15));
      stall = (c >= slo && c <= shi);
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        rd[k][c]  = int'(d[k]);
        rv[k][c]  = int'(v[k]);
        rb[k][c]  = int'(b[k]);
        rdn[k][c] = int'(dn[k]);
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    stall = 1'b0;
  endtask

  function automatic int first_done(input int k, input int n);
    for (int c = 0; c < n; c++) if (rdn[k][c] == 1) return c;
    return -1;
  endfunction

  function automatic int vword(input int k, input int n);
    int w = 0;
    for (int c = 0; c < n; c++) if (rv[k][c] == 1) w = (w << 1) | rd[k][c];
    return w;
  endfunction

  function automatic int vcount(input int k, input int n);
    int s = 0;
    for (int c = 0; c < n; c++) s += rv[k][c];
    return s;
  endfunction

  int acc;
  int wait_cnt;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_d", int'(d), 0);
    chk("reset_valid", int'(v), 0);
    chk("reset_busy", int'(b), 0);
    chk("reset_done", int'(dn), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single repetition.
    burst(1, -1, -1, 1'b0, 10);
    for (int c = 1; c <= 5; c++) begin
      chk($sformatf("r1_bit%0d", c), rd[0][c], int'(PAT[5 - c]));
      chk($sformatf("r1_valid%0d", c), rv[0][c], 1);
    end
    chk("r1_done_cycle", first_done(0, 10), 6);
    chk("r1_idle_c7", rb[0][7], 0);
    chk("r1_nogap_done_cycle", first_done(1, 10), 6);

    // Two repetitions: gap of 2 versus back-to-back.
    burst(2, -1, -1, 1'b0, 16);
    chk("r2_gap_stream", vword(0, 16), 12'b1011_0001_0110);
    chk("r2_gap_count", vcount(0, 16), 12);
    chk("r2_gap_done_cycle", first_done(0, 16), 13);
    chk("r2_gap_detect", det_last[0], 2);
    chk("r2_nogap_stream", vword(1, 16), 10'b10_1101_0110);
    chk("r2_nogap_count", vcount(1, 16), 10);
    chk("r2_nogap_done_cycle", first_done(1, 16), 11);
    chk("r2_nogap_detect", det_last[1], 2);

    // Stall during cycles 3-4.
    burst(1, 3, 4, 1'b0, 12);
    chk("stall_v3", rv[0][3], 0);
    chk("stall_v4", rv[0][4], 0);
    chk("stall_d3", rd[0][3], 1);
    chk("stall_d4", rd[0][4], 1);
    chk("stall_stream", vword(0, 12), 5'b10110);
    chk("stall_done_cycle", first_done(0, 12), 8);

    // rep_i == 0 is ignored.
    burst(0, -1, -1, 1'b0, 6);
    acc = 0;
    for (int c = 0; c < 6; c++) acc += rb[0][c] + rv[0][c] + rdn[0][c];
    chk("rep0_no_activity", acc, 0);

    // Starts while busy are ignored.
    burst(3, -1, -1, 1'b1, 24);
    chk("busy_start_done_cycle", first_done(0, 24), 20);

    // Reset mid-burst.
    start = 1'b1;
    rep   = 4'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_d", int'(d), 0);
    chk("rst_mid_valid", int'(v), 0);
    chk("rst_mid_busy", int'(b), 0);
    chk("rst_mid_done", int'(dn), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    acc = 0;
    repeat (10) begin
      @(negedge clk);
      acc += int'(dn[0]) + int'(dn[1]);
    end
    chk("rst_no_done", acc, 0);
    @(posedge clk);
    #1;
    burst(1, -1, -1, 1'b0, 10);
    chk("after_rst_done_cycle", first_done(0, 10), 6);

    // Randomized traffic with stalls, stray starts and resets.
    for (int it = 0; it < 40; it++) begin
      for (int c = 0; c < 150; c++) begin
        start = ($urandom_range(5) == 0);
        rep   = 4'($urandom_range(15));
        stall = ($urandom_range(3) == 0);
        if ($urandom_range(400) == 0) rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
      end
      start = 1'b0;
      stall = 1'b0;
      wait_cnt = 0;
      while ((b[0] || b[1]) && wait_cnt < 300) begin
        @(posedge clk);
        #1;
        wait_cnt++;
      end
      chk("drain_timeout", int'(b[0] || b[1]), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
